fetch_ifid_stage: RTL and testbench

// Fetch controller and IF/ID pipeline register sitting directly downstream of the PC register.

---
 rtl/fetch_ifid_if.sv | 27 ++
 rtl/fetch_ifid_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_ifid_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ifid_if.sv
// Bundle of the fetch stage's PC, hazard, instruction-memory and IF/ID signals.
// The master side is the fetch stage; the slave side is its environment.
interface fetch_ifid_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc;
    logic             pcWrite;
    logic             stall;
    logic             flush;
    logic             imemReq;
    logic [WIDTH-1:0] imemAddr;
    logic             imemAck;
    logic [WIDTH-1:0] imemData;
    logic             idValid;
    logic [WIDTH-1:0] idInstr;
    logic [WIDTH-1:0] idPcPlus4;

    modport master (
        input  pc, stall, flush, imemAck, imemData,
        output pcWrite, imemReq, imemAddr, idValid, idInstr, idPcPlus4
    );

    modport slave (
        output pc, stall, flush, imemAck, imemData,
        input  pcWrite, imemReq, imemAddr, idValid, idInstr, idPcPlus4
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Fetch controller plus IF/ID register: requests the instruction at pc from a
// variable-latency memory, drives pcWrite, and honours stall and flush.
module fetch_ifid_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ifid_if.master bus,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] hold_buf_q, hold_buf_d;
    logic             id_valid_q, id_valid_d;
    logic [WIDTH-1:0] id_instr_q, id_instr_d;
    logic [WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;

    logic             req;
    logic             ack_ok;
    logic             pc_write;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_addr_plus4;

    // Memory handshake: imemReq stays high with a stable imemAddr until the cycle
    // imemAck is seen; an ack while imemReq is low is not a transfer.
    always_comb begin
        req            = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_DRAIN);
        req_addr       = (state_q == S_FETCH) ? bus.pc : addr_q;
        req_addr_plus4 = req_addr + WIDTH'(4);
        ack_ok         = bus.imemAck && req;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        hold_buf_d    = hold_buf_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        pc_write      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH, S_WAIT: begin
                if (state_q == S_FETCH) begin
                    addr_d = bus.pc;
                end
                if (bus.flush) begin
                    // Squash: a request still open after this edge must be drained.
                    pc_write   = 1'b1;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    hold_buf_d = NOP_INSTR;
                    state_d    = ack_ok ? S_FETCH : S_DRAIN;
                end else if (ack_ok && !bus.stall) begin
                    pc_write      = 1'b1;
                    id_valid_d    = 1'b1;
                    id_instr_d    = bus.imemData;
                    id_pc_plus4_d = req_addr_plus4;
                    state_d       = S_FETCH;
                end else if (ack_ok) begin
                    hold_buf_d = bus.imemData;
                    state_d    = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                    if (!bus.stall) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end
                end
            end

            S_HOLD: begin
                if (bus.flush) begin
                    pc_write   = 1'b1;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    hold_buf_d = NOP_INSTR;
                    state_d    = S_FETCH;
                end else if (!bus.stall) begin
                    pc_write      = 1'b1;
                    id_valid_d    = 1'b1;
                    id_instr_d    = hold_buf_q;
                    id_pc_plus4_d = req_addr_plus4;
                    state_d       = S_FETCH;
                end
            end

            S_DRAIN: begin
                if (bus.flush) begin
                    pc_write   = 1'b1;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    hold_buf_d = NOP_INSTR;
                    state_d    = ack_ok ? S_FETCH : S_DRAIN;
                end else begin
                    // Returning data belongs to a squashed fetch and is dropped.
                    if (ack_ok) begin
                        state_d = S_FETCH;
                    end
                    if (!bus.stall) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            hold_buf_q    <= NOP_INSTR;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            hold_buf_q    <= hold_buf_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign bus.pcWrite   = pc_write;
    assign bus.imemReq   = req;
    assign bus.imemAddr  = req_addr;
    assign bus.idValid   = id_valid_q;
    assign bus.idInstr   = id_instr_q;
    assign bus.idPcPlus4 = id_pc_plus4_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: instruction-level reference model with a memory
// responder, an expected-entry queue and an independent IF/ID monitor.
module tb_fetch_ifid_stage;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    fetch_ifid_if #(.WIDTH(W)) bus ();

    fetch_ifid_stage #(.WIDTH(W), .NOP_INSTR('0)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected IF/ID entries in delivery order: {instr, pc_plus4}.
    logic [2*W-1:0] exp_q[$];

    // Reference model: PC register, pending fetched word, outstanding request.
    logic [W-1:0] pc_m;
    bit           pend_v;
    logic [W-1:0] pend_i, pend_p;
    bit           out_act, out_sq;
    logic [W-1:0] out_addr;
    int           out_lat, out_cnt;
    bit           idle_cycle;
    logic         stall_prev;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A50F17;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        pc_m       = '0;
        pend_v     = 0;
        out_act    = 0;
        out_sq     = 0;
        idle_cycle = 1;
        exp_q.delete();
        bus.pc       = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.imemAck  = 1'b0;
        bus.imemData = '0;
    endtask

    // One clock cycle, entered and left at posedge+1. lat < 0 picks a random latency
    // for a request that starts in this cycle.
    task automatic cycle(input bit st, input bit fl, input logic [W-1:0] tgt, input int lat);
        bit           exp_req, ack, push_now, fl_e;
        logic [W-1:0] dat;
        fl_e    = fl && !idle_cycle;
        exp_req = !idle_cycle && !pend_v;
        ack     = 0;
        dat     = $urandom;
        if (exp_req) begin
            if (!out_act) begin
                out_act  = 1;
                out_addr = pc_m;
                out_lat  = (lat < 0) ? $urandom_range(0, 3) : lat;
                out_cnt  = 0;
                out_sq   = 0;
            end
            ack = (out_cnt == out_lat);
            if (ack) dat = mem_word(out_addr);
        end else begin
            ack = ($urandom_range(0, 3) == 0);
        end
        bus.stall    = st;
        bus.flush    = fl_e;
        bus.imemAck  = ack;
        bus.imemData = dat;
        #1;
        check("imemReq", W'(bus.imemReq), W'(exp_req));
        if (exp_req) check("imemAddr", bus.imemAddr, out_addr);
        push_now = 0;
        if (exp_req) begin
            if (ack) begin
                out_act = 0;
                if (!fl_e && !out_sq) begin
                    pend_v = 1;
                    pend_i = dat;
                    pend_p = out_addr + 32'd4;
                end
            end else begin
                out_cnt++;
                if (fl_e) out_sq = 1;
            end
        end
        if (fl_e) begin
            pend_v = 0;
        end else if (pend_v && !st) begin
            exp_q.push_back({pend_i, pend_p});
            pend_v   = 0;
            push_now = 1;
        end
        check("pcWrite", W'(bus.pcWrite), W'(fl_e || push_now));
        @(posedge clk);
        #1;
        idle_cycle = 0;
        if (fl_e) pc_m = tgt;
        else if (push_now) pc_m = pc_m + 32'd4;
        bus.pc = pc_m;
    endtask

    // Monitor: a fresh IF/ID entry appears on any edge taken with stall low.
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (rst) begin
            stall_prev = 1'b1;
        end else begin
            if (bus.idValid && !stall_prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_entry: got %h/%h expected none", bus.idInstr, bus.idPcPlus4);
                end else begin
                    e = exp_q.pop_front();
                    check("idInstr", bus.idInstr, e[2*W-1:W]);
                    check("idPcPlus4", bus.idPcPlus4, e[W-1:0]);
                end
            end
            stall_prev = bus.stall;
        end
    end

    initial begin
        logic [W-1:0] tgt;
        rst = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("reset_idValid", W'(bus.idValid), '0);
        check("reset_imemReq", W'(bus.imemReq), '0);
        rst = 1'b0;

        // Zero-wait stream
        cycle(0, 0, '0, 0);
        repeat (3) cycle(0, 0, '0, 0);
        check("stream_idValid", W'(bus.idValid), 32'd1);
        check("stream_idInstr", bus.idInstr, mem_word(32'h8));
        check("stream_idPcPlus4", bus.idPcPlus4, 32'hC);

        // Latency 3 at 0x40
        cycle(0, 1, 32'h40, 0);
        check("flush_bubble", W'(bus.idValid), '0);
        cycle(0, 0, '0, 2);
        check("lat_wait1_idValid", W'(bus.idValid), '0);
        cycle(0, 0, '0, 2);
        check("lat_wait2_idValid", W'(bus.idValid), '0);
        cycle(0, 0, '0, 2);
        check("lat_idInstr", bus.idInstr, mem_word(32'h40));
        check("lat_idPcPlus4", bus.idPcPlus4, 32'h44);

        // Stall at ack for two cycles
        cycle(1, 0, '0, 0);
        check("stall1_idInstr", bus.idInstr, mem_word(32'h40));
        cycle(1, 0, '0, 0);
        check("stall2_idInstr", bus.idInstr, mem_word(32'h40));
        cycle(0, 0, '0, 0);
        check("release_idInstr", bus.idInstr, mem_word(32'h44));
        check("release_idPcPlus4", bus.idPcPlus4, 32'h48);

        // Flush while waiting on 0x80
        cycle(0, 1, 32'h80, 0);
        cycle(0, 0, '0, 3);
        cycle(0, 1, 32'h100, 3);
        cycle(0, 0, '0, 3);
        cycle(0, 0, '0, 3);
        check("drain_idValid", W'(bus.idValid), '0);
        cycle(0, 0, '0, 0);
        check("after_drain_idPcPlus4", bus.idPcPlus4, 32'h104);

        // PC+4 wrap
        cycle(0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, '0, 0);
        check("wrap_idValid", W'(bus.idValid), 32'd1);
        check("wrap_idPcPlus4", bus.idPcPlus4, '0);

        // Asynchronous reset in the middle of a wait
        cycle(1, 0, '0, 3);
        check("prereset_idValid", W'(bus.idValid), 32'd1);
        #2;
        rst = 1'b1;
        bus.imemAck = 1'b0;
        #1;
        check("rst_idValid", W'(bus.idValid), '0);
        check("rst_idInstr", bus.idInstr, '0);
        check("rst_idPcPlus4", bus.idPcPlus4, '0);
        check("rst_pcWrite", W'(bus.pcWrite), '0);
        check("rst_imemReq", W'(bus.imemReq), '0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8;
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, tgt, -1);
        end
        repeat (8) cycle(0, 0, '0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
